// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the 8:1 round-robin mux arbiter.
package mux8_arb_pkg;

   localparam int WIDTH = 64;
   localparam int N     = 8;
   localparam int SEL_W = 3;

   // Last-grant pointer at reset: requester 0 is scanned first.
   localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/mux_64bit_8to1.sv
// 8:1 word multiplexer; S selects A (0) through H (7).
module mux_64bit_8to1 #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] E,
   input  logic [WIDTH-1:0] F,
   input  logic [WIDTH-1:0] G,
   input  logic [WIDTH-1:0] H,
   input  logic [2:0]       S,
   output logic [WIDTH-1:0] Y
);

   always_comb begin
      Y = A;
      case (S)
         3'd0: Y = A;
         3'd1: Y = B;
         3'd2: Y = C;
         3'd3: Y = D;
         3'd4: Y = E;
         3'd5: Y = F;
         3'd6: Y = G;
         3'd7: Y = H;
      endcase
   end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request scanning ptr+1, ptr+2, ... modulo N.
module rr_pick8
   import mux8_arb_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      // k = N wraps back onto ptr itself, so the last holder is scanned last.
      for (int k = 1; k <= N; k++) begin
         cand = ptr + SEL_W'(k);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      grant = '0;
      if (any) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the 64-bit 8:1 mux into a one-entry valid/ready register.
// Optional burst lock on the last winner: define MUX8_RR_ARBITER_LOCK_EN.
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
`ifdef MUX8_RR_ARBITER_LOCK_EN
   input  logic               lock,
`endif
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] din,
   output logic [N-1:0]       grant,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src
);

   state_t           state;
   state_t           state_next;
   logic [SEL_W-1:0] ptr;

   logic [N-1:0]     pick_grant;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic [N-1:0]     win_grant;
   logic [SEL_W-1:0] win_idx;
   logic             can_load;
   logic             load;
   logic [WIDTH-1:0] mux_y;

   rr_pick8 u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

`ifdef MUX8_RR_ARBITER_LOCK_EN
   logic lock_hit;

   // A locked holder that still requests keeps the mux, overriding rotation.
   assign lock_hit  = lock && req[ptr];
   assign win_idx   = lock_hit ? ptr : pick_idx;
   assign win_grant = lock_hit ? (N'(1) << ptr) : pick_grant;
`else
   assign win_idx   = pick_idx;
   assign win_grant = pick_grant;
`endif

   assign out_valid = (state == FULL);
   assign can_load  = !out_valid || out_ready;
   assign load      = can_load && pick_any;
   assign grant     = load ? win_grant : '0;

   mux_64bit_8to1 #(.WIDTH(WIDTH)) u_mux (
      .A (din[0*WIDTH +: WIDTH]),
      .B (din[1*WIDTH +: WIDTH]),
      .C (din[2*WIDTH +: WIDTH]),
      .D (din[3*WIDTH +: WIDTH]),
      .E (din[4*WIDTH +: WIDTH]),
      .F (din[5*WIDTH +: WIDTH]),
      .G (din[6*WIDTH +: WIDTH]),
      .H (din[7*WIDTH +: WIDTH]),
      .S (win_idx),
      .Y (mux_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (pick_any) state_next = FULL;
         FULL:    if (out_ready && !pick_any) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // Output register stage: loads only on an edge that issues a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_src  <= '0;
         ptr      <= PTR_RST;
      end else if (load) begin
         out_data <= mux_y;
         out_src  <= win_idx;
         ptr      <= win_idx;
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a reference round-robin model predicts grants
// and queues the expected captured words, popped when the consumer accepts them.
module tb_mux8_rr_arbiter;
   import mux8_arb_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] din;
   logic [N-1:0]       grant;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_src;
`ifdef MUX8_RR_ARBITER_LOCK_EN
   logic               lock;
`endif

   mux8_rr_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MUX8_RR_ARBITER_LOCK_EN
      .lock      (lock),
`endif
      .req       (req),
      .din       (din),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  src;
   } item_t;

   item_t       sb[$];
   logic [2:0]  m_ptr;
   logic        m_valid;
   logic [7:0]  exp_grant;
   logic [2:0]  exp_idx;
   logic [63:0] pat [8];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [7:0] ref_pick(input logic [7:0] r, input logic [2:0] p,
                                           input logic lk, output logic [2:0] w);
      logic [7:0] g;
      logic       found;
      g = 8'h00;
      w = 3'd0;
      found = 1'b0;
      if (lk && r[p]) begin
         g = 8'h01 << p;
         w = p;
         found = 1'b1;
      end
      for (int k = 1; k <= 8; k++) begin
         int i;
         i = (int'(p) + k) % 8;
         if (!found && r[i]) begin
            g = 8'h01 << i;
            w = 3'(i);
            found = 1'b1;
         end
      end
      return g;
   endfunction

   task automatic model_reset();
      m_ptr   = 3'd7;
      m_valid = 1'b0;
      sb.delete();
   endtask

   // Compute the expected grant for the coming edge from the current inputs.
   task automatic predict();
      logic lk;
`ifdef MUX8_RR_ARBITER_LOCK_EN
      lk = lock;
`else
      lk = 1'b0;
`endif
      if (m_valid && !out_ready) begin
         exp_grant = 8'h00;
         exp_idx   = 3'd0;
      end else begin
         exp_grant = ref_pick(req, m_ptr, lk, exp_idx);
      end
   endtask

   // Apply the coming edge to the model, then move to just after that edge.
   task automatic advance();
      item_t it;
      if (m_valid && out_ready) void'(sb.pop_front());
      if (exp_grant != 8'h00) begin
         it.data = din[int'(exp_idx)*64 +: 64];
         it.src  = exp_idx;
         sb.push_back(it);
         m_ptr = exp_idx;
      end
      m_valid = (m_valid && !out_ready) || (exp_grant != 8'h00);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic load_patterns();
      for (int i = 0; i < 8; i++) din[i*64 +: 64] = pat[i];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
      n_checks++;
      if (out_src !== 3'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", out_src); end
      n_checks++;
      if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant: got %h want 00", grant); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      din = '0;
      din[63:0] = 64'hAAAA_AAAA_AAAA_AAAA;
      req = 8'h01;
      out_ready = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== exp_grant || grant !== 8'h01) begin
         n_fail++; $display("FAIL single_grant: got %h want 01 (model %h)", grant, exp_grant);
      end
      advance();
      req = 8'h00;
      @(negedge clk);
      predict();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hAAAA_AAAA_AAAA_AAAA || out_src !== 3'd0) begin
         n_fail++; $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=AAAAAAAAAAAAAAAA s=0",
                            out_valid, out_data, out_src);
      end
      n_checks++;
      if (out_data !== sb[0].data || out_src !== sb[0].src) begin
         n_fail++; $display("FAIL single_sb: got %h/%0d want %h/%0d", out_data, out_src, sb[0].data, sb[0].src);
      end
      n_checks++;
      if (grant !== exp_grant) begin n_fail++; $display("FAIL idle_grant: got %h want %h", grant, exp_grant); end
      advance();
      @(negedge clk);
      predict();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
      advance();
   endtask

   task automatic test_back_to_back();
      do_reset();
      load_patterns();
      req = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         predict();
         n_checks++;
         if (grant !== exp_grant || grant !== (8'h01 << (k % 8))) begin
            n_fail++; $display("FAIL b2b_grant[%0d]: got %h want %h", k, grant, 8'h01 << (k % 8));
         end
         if (k > 0) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 3'((k - 1) % 8) || out_data !== pat[(k - 1) % 8]) begin
               n_fail++; $display("FAIL b2b_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                                  k, out_valid, out_src, out_data, (k - 1) % 8, pat[(k - 1) % 8]);
            end
            n_checks++;
            if (out_data !== sb[0].data || out_src !== sb[0].src) begin
               n_fail++; $display("FAIL b2b_sb[%0d]: got %h/%0d want %h/%0d", k, out_data, out_src, sb[0].data, sb[0].src);
            end
         end
         advance();
      end
      req = 8'h00;
      @(negedge clk);
      predict();
      advance();
   endtask

   task automatic test_stall();
      do_reset();
      load_patterns();
      req = 8'h08;
      out_ready = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h08) begin n_fail++; $display("FAIL stall_setup_grant: got %h want 08", grant); end
      advance();
      req = 8'hF0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         predict();
         n_checks++;
         if (grant !== 8'h00 || grant !== exp_grant) begin
            n_fail++; $display("FAIL stall_grant[%0d]: got %h want 00", c, grant);
         end
         n_checks++;
         if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== pat[3]) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=3 d=%h",
                               c, out_valid, out_src, out_data, pat[3]);
         end
         advance();
      end
      out_ready = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h10 || grant !== exp_grant) begin
         n_fail++; $display("FAIL stall_release_grant: got %h want 10", grant);
      end
      advance();
      req = 8'h00;
      @(negedge clk);
      predict();
      n_checks++;
      if (out_src !== 3'd4 || out_data !== sb[0].data || out_src !== sb[0].src) begin
         n_fail++; $display("FAIL stall_next_src: got %0d/%h want 4/%h", out_src, out_data, sb[0].data);
      end
      advance();
   endtask

   task automatic test_wrap();
      req = 8'h40;
      out_ready = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h40 || grant !== exp_grant) begin n_fail++; $display("FAIL wrap_setup: got %h want 40", grant); end
      advance();
      req = 8'h41;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h01 || grant !== exp_grant) begin n_fail++; $display("FAIL wrap_grant: got %h want 01", grant); end
      n_checks++;
      if (out_src !== 3'd6) begin n_fail++; $display("FAIL wrap_src6: got %0d want 6", out_src); end
      advance();
      req = 8'h40;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h40 || grant !== exp_grant) begin n_fail++; $display("FAIL wrap_back: got %h want 40", grant); end
      n_checks++;
      if (out_src !== 3'd0 || out_data !== sb[0].data) begin
         n_fail++; $display("FAIL wrap_src0: got %0d/%h want 0/%h", out_src, out_data, sb[0].data);
      end
      advance();
      req = 8'h00;
      @(negedge clk);
      predict();
      advance();
      @(negedge clk);
      predict();
      advance();
   endtask

   task automatic test_reset_mid();
      req = 8'hFF;
      out_ready = 1'b1;
      @(negedge clk);
      predict();
      advance();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || out_src !== 3'd0) begin
         n_fail++; $display("FAIL midrst_async: got v=%b d=%h s=%0d want 0/0/0", out_valid, out_data, out_src);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h01 || grant !== exp_grant) begin n_fail++; $display("FAIL midrst_first_grant: got %h want 01", grant); end
      advance();
      req = 8'h00;
      @(negedge clk);
      predict();
      n_checks++;
      if (out_src !== 3'd0 || out_data !== pat[0] || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL midrst_out: got v=%b s=%0d d=%h want v=1 s=0 d=%h", out_valid, out_src, out_data, pat[0]);
      end
      advance();
   endtask

`ifdef MUX8_RR_ARBITER_LOCK_EN
   task automatic test_lock();
      lock = 1'b0;
      req = 8'h20;
      out_ready = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h20 || grant !== exp_grant) begin n_fail++; $display("FAIL lock_setup: got %h want 20", grant); end
      advance();
      lock = 1'b1;
      req = 8'hFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         predict();
         n_checks++;
         if (grant !== 8'h20 || grant !== exp_grant) begin n_fail++; $display("FAIL lock_grant[%0d]: got %h want 20", c, grant); end
         n_checks++;
         if (out_src !== 3'd5 || out_data !== pat[5]) begin
            n_fail++; $display("FAIL lock_src[%0d]: got %0d want 5", c, out_src);
         end
         advance();
      end
      lock = 1'b0;
      @(negedge clk);
      predict();
      n_checks++;
      if (grant !== 8'h40 || grant !== exp_grant) begin n_fail++; $display("FAIL unlock_grant: got %h want 40", grant); end
      advance();
      req = 8'h00;
      @(negedge clk);
      predict();
      n_checks++;
      if (out_src !== 3'd6 || out_data !== pat[6]) begin n_fail++; $display("FAIL unlock_src: got %0d want 6", out_src); end
      advance();
   endtask
`endif

   initial begin
      pat[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      pat[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      pat[2] = 64'hCCCC_CCCC_CCCC_CCCC;
      pat[3] = 64'hDDDD_DDDD_DDDD_DDDD;
      pat[4] = 64'hEEEE_EEEE_EEEE_EEEE;
      pat[5] = 64'hFFFF_FFFF_FFFF_FFFF;
      pat[6] = 64'h1111_1111_1111_1111;
      pat[7] = 64'h2222_2222_2222_2222;
      rst_n = 1'b0;
      req = 8'h00;
      din = '0;
      out_ready = 1'b0;
`ifdef MUX8_RR_ARBITER_LOCK_EN
      lock = 1'b0;
`endif
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_wrap();
      test_reset_mid();
`ifdef MUX8_RR_ARBITER_LOCK_EN
      test_lock();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
